// File: rtl/bt_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bt_cmd_decoder
// Purpose  : 8N1 UART receiver that decodes ASCII player commands into track
//            select, VS1003 SCI_VOL volume word, pause state and event pulses.
//            Optional macro BT_ACK_EN adds an 8N1 echo of each recognised
//            command byte on txd; without it txd is held idle high.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module bt_cmd_decoder #(
    parameter int         CLK_HZ      = 100000000,
    parameter int         BAUD        = 9600,
    parameter int         TRACKS      = 4,
    parameter int         TRACK_W     = 2,
    parameter logic [7:0] VOL_DEFAULT = 8'h20,
    parameter logic [7:0] VOL_STEP    = 8'h10,
    parameter logic [7:0] VOL_MAX_ATT = 8'hFE
) (
    input  logic               clk,
    input  logic               init,
    input  logic               rxd,
    output logic [TRACK_W-1:0] track,
    output logic [15:0]        volume,
    output logic               paused,
    output logic               track_change,
    output logic               cmd_valid,
    output logic               frame_err,
    output logic               txd
);

    localparam int c_bit_cnt = CLK_HZ / BAUD;
    localparam int c_cnt_w   = $clog2(c_bit_cnt + 1);

    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(c_bit_cnt);
    localparam logic [c_cnt_w-1:0] c_half    = c_cnt_w'(c_bit_cnt / 2);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);
    localparam logic [TRACK_W-1:0] c_last    = TRACK_W'(TRACKS - 1);
    localparam logic [TRACK_W-1:0] c_trk_one = TRACK_W'(1);
    localparam logic [7:0]         c_tracks8 = 8'(TRACKS);

    localparam logic [7:0] c_ch_next  = 8'h6E;  // 'n'
    localparam logic [7:0] c_ch_prev  = 8'h70;  // 'p'
    localparam logic [7:0] c_ch_up    = 8'h2B;  // '+' : louder
    localparam logic [7:0] c_ch_down  = 8'h2D;  // '-' : quieter
    localparam logic [7:0] c_ch_pause = 8'h20;  // ' '

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    rx_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_byte_valid, w_byte_valid_nxt;
    logic               r_frame_err, w_frame_err_nxt;

    logic r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic w_fall, w_expire;

    logic [TRACK_W-1:0] r_track;
    logic [7:0]         r_att;
    logic               r_paused, r_track_change, r_cmd_valid;
    logic [7:0]         w_digit;
    logic               w_is_digit;
    logic [8:0]         w_att_up;

    // Two-flop synchroniser plus a delayed copy for start-edge detection
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    assign w_fall   = r_rxd_prev & ~r_rxd_sync;
    assign w_expire = (r_cnt <= c_one);

    // RX state register; a reset mid-frame drops the partial byte
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    // RX next state: half-bit to mid-start, then one bit period per sample
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = (r_cnt != '0) ? (r_cnt - c_one) : r_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = c_half;
                end
            end
            S_START: begin
                if (w_expire) begin
                    if (!r_rxd_sync) begin
                        w_state_nxt   = S_DATA;
                        w_cnt_nxt     = c_full;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;   // start bit too short: glitch
                    end
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    w_shift_nxt = {r_rxd_sync, r_shift[7:1]};
                    w_cnt_nxt   = c_full;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    w_byte_valid_nxt = r_rxd_sync;
                    w_frame_err_nxt  = ~r_rxd_sync;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_digit    = r_shift - 8'h30;
    assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39) && (w_digit < c_tracks8);
    assign w_att_up   = {1'b0, r_att} + {1'b0, VOL_STEP};

    // Command decode, one clock after the byte is accepted
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_track        <= '0;
            r_att          <= VOL_DEFAULT;
            r_paused       <= 1'b0;
            r_track_change <= 1'b0;
            r_cmd_valid    <= 1'b0;
        end else begin
            r_track_change <= 1'b0;
            r_cmd_valid    <= 1'b0;
            if (r_byte_valid) begin
                if (w_is_digit) begin
                    r_track        <= w_digit[TRACK_W-1:0];
                    r_paused       <= 1'b0;
                    r_track_change <= 1'b1;
                    r_cmd_valid    <= 1'b1;
                end else begin
                    case (r_shift)
                        c_ch_next: begin
                            r_track        <= (r_track == c_last) ? '0 : r_track + c_trk_one;
                            r_paused       <= 1'b0;
                            r_track_change <= 1'b1;
                            r_cmd_valid    <= 1'b1;
                        end
                        c_ch_prev: begin
                            r_track        <= (r_track == '0) ? c_last : r_track - c_trk_one;
                            r_paused       <= 1'b0;
                            r_track_change <= 1'b1;
                            r_cmd_valid    <= 1'b1;
                        end
                        c_ch_up: begin
                            r_att       <= (r_att < VOL_STEP) ? 8'h00 : r_att - VOL_STEP;
                            r_cmd_valid <= 1'b1;
                        end
                        c_ch_down: begin
                            r_att       <= (w_att_up > {1'b0, VOL_MAX_ATT}) ? VOL_MAX_ATT : w_att_up[7:0];
                            r_cmd_valid <= 1'b1;
                        end
                        c_ch_pause: begin
                            r_paused    <= ~r_paused;
                            r_cmd_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign track        = r_track;
    assign volume       = {r_att, r_att};
    assign paused       = r_paused;
    assign track_change = r_track_change;
    assign cmd_valid    = r_cmd_valid;
    assign frame_err    = r_frame_err;

`ifdef BT_ACK_EN
    logic               r_tx_busy, r_txd;
    logic [8:0]         r_tx_shift;
    logic [3:0]         r_tx_bits;
    logic [c_cnt_w-1:0] r_tx_cnt;

    // Echo transmitter; commands arriving while busy are not acknowledged.
    // r_shift still holds the decoded byte during the cmd_valid cycle.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_tx_busy  <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_shift <= '1;
            r_tx_bits  <= '0;
            r_tx_cnt   <= '0;
        end else if (!r_tx_busy) begin
            if (r_cmd_valid) begin
                r_tx_busy  <= 1'b1;
                r_txd      <= 1'b0;
                r_tx_shift <= {1'b1, r_shift};
                r_tx_bits  <= 4'd9;
                r_tx_cnt   <= c_full;
            end
        end else if (r_tx_cnt <= c_one) begin
            if (r_tx_bits == 4'd0) begin
                r_tx_busy <= 1'b0;
            end else begin
                r_txd      <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bits  <= r_tx_bits - 4'd1;
                r_tx_cnt   <= c_full;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt - c_one;
        end
    end

    assign txd = r_txd;
`else
    assign txd = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bt_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bt_cmd_decoder
// Purpose  : Self-checking bench for bt_cmd_decoder with a reduced bit period;
//            a reference model queues expected outputs per command byte and a
//            negedge monitor compares them on each cmd_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bt_cmd_decoder;

    localparam int         c_clk_hz  = 160;
    localparam int         c_baud    = 10;
    localparam int         c_bit     = c_clk_hz / c_baud;   // 16 clocks per bit
    localparam int         c_tracks  = 4;
    localparam logic [7:0] c_vol_def = 8'h20;
    localparam logic [7:0] c_step    = 8'h10;
    localparam logic [7:0] c_max     = 8'hFE;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        rxd = 1'b1;
    logic [1:0]  track;
    logic [15:0] volume;
    logic        paused, track_change, cmd_valid, frame_err, txd;

    typedef struct packed {
        logic [1:0]  trk;
        logic [15:0] vol;
        logic        pau;
        logic        tc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_cmd    = 0;
    int n_fe     = 0;
    logic prev_cv = 1'b0;
    logic prev_fe = 1'b0;

    logic [1:0] m_track  = 2'd0;
    logic [7:0] m_att    = c_vol_def;
    logic       m_paused = 1'b0;

    bt_cmd_decoder #(
        .CLK_HZ      (c_clk_hz),
        .BAUD        (c_baud),
        .TRACKS      (c_tracks),
        .TRACK_W     (2),
        .VOL_DEFAULT (c_vol_def),
        .VOL_STEP    (c_step),
        .VOL_MAX_ATT (c_max)
    ) u_dut (
        .clk          (clk),
        .init         (init),
        .rxd          (rxd),
        .track        (track),
        .volume       (volume),
        .paused       (paused),
        .track_change (track_change),
        .cmd_valid    (cmd_valid),
        .frame_err    (frame_err),
        .txd          (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: update state and queue the expected outputs
    task automatic model_cmd(input logic [7:0] b);
        logic       hit;
        logic       tc;
        logic [7:0] d;
        int         a;
        hit = 1'b0;
        tc  = 1'b0;
        d   = b - 8'h30;
        if (b >= 8'h30 && b <= 8'h39) begin
            if (int'(d) < c_tracks) begin
                m_track = 2'(d); m_paused = 1'b0; hit = 1'b1; tc = 1'b1;
            end
        end else begin
            case (b)
                8'h6E: begin
                    m_track = 2'((int'(m_track) + 1) % c_tracks);
                    m_paused = 1'b0; hit = 1'b1; tc = 1'b1;
                end
                8'h70: begin
                    m_track = 2'((int'(m_track) + c_tracks - 1) % c_tracks);
                    m_paused = 1'b0; hit = 1'b1; tc = 1'b1;
                end
                8'h2B: begin
                    m_att = (m_att >= c_step) ? m_att - c_step : 8'h00; hit = 1'b1;
                end
                8'h2D: begin
                    a = int'(m_att) + int'(c_step);
                    m_att = (a > int'(c_max)) ? c_max : 8'(a); hit = 1'b1;
                end
                8'h20: begin
                    m_paused = ~m_paused; hit = 1'b1;
                end
                default: ;
            endcase
        end
        if (hit) sb_q.push_back('{m_track, {m_att, m_att}, m_paused, tc});
    endtask

    task automatic scoreboard_step();
        exp_t e;
        if (init) return;
        if (cmd_valid) begin
            t_cmd = cyc;
            check_eq("cmd_valid_width", 32'(prev_cv), 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("spurious_cmd_valid", 32'(cmd_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("track", 32'(track), 32'(e.trk));
                check_eq("volume", 32'(volume), 32'(e.vol));
                check_eq("paused", 32'(paused), 32'(e.pau));
                check_eq("track_change", 32'(track_change), 32'(e.tc));
            end
        end
        if (track_change && !cmd_valid) check_eq("tc_without_cv", 32'(track_change), 32'd0);
        if (frame_err) begin
            n_fe++;
            check_eq("frame_err_width", 32'(prev_fe), 32'd0);
            check_eq("frame_err_cmd", 32'(cmd_valid), 32'd0);
        end
        prev_cv = cmd_valid;
        prev_fe = frame_err;
    endtask

    always @(negedge clk) scoreboard_step();

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(posedge clk); #1;
        if (stop_ok) model_cmd(b);
        t_start = cyc;
        drive_bit(1'b0, c_bit);
        for (int i = 0; i < 8; i++) drive_bit(b[i], c_bit);
        drive_bit(stop_ok, c_bit);
        drive_bit(1'b1, 2 * c_bit);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_track"}, 32'(track), 32'(m_track));
        check_eq({tag, "_volume"}, 32'(volume), 32'({m_att, m_att}));
        check_eq({tag, "_paused"}, 32'(paused), 32'(m_paused));
        check_eq({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic model_reset();
        m_track = 2'd0; m_att = c_vol_def; m_paused = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_track"}, 32'(track), 32'd0);
        check_eq({tag, "_volume"}, 32'(volume), 32'h2020);
        check_eq({tag, "_paused"}, 32'(paused), 32'd0);
        check_eq({tag, "_pulses"}, 32'({track_change, cmd_valid, frame_err}), 32'd0);
        check_eq({tag, "_txd"}, 32'(txd), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init = 1'b0;
        model_reset();
        sb_q.delete();
    endtask

`ifdef BT_ACK_EN
    task automatic ack_capture();
        int         k;
        logic [7:0] got;
        k = 0;
        while (!cmd_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("ack_cmd_seen", 32'(cmd_valid), 32'd1);
        @(negedge clk);
        check_eq("ack_start_bit", 32'(txd), 32'd0);
        repeat (c_bit / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (c_bit) @(negedge clk);
            got[i] = txd;
        end
        repeat (c_bit) @(negedge clk);
        check_eq("ack_stop_bit", 32'(txd), 32'd1);
        check_eq("ack_byte", 32'(got), 32'h6E);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int fe0;
        repeat (4) @(posedge clk);
        #1;
        check_reset_values("reset");
        init = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);

        // First command and decode latency from start edge
        send_byte(8'h32, 1'b1);
        d = t_cmd - t_start;
        check_eq("latency_window",
                 32'((d >= 9 * c_bit + c_bit / 2) && (d <= 9 * c_bit + c_bit / 2 + 6)), 32'd1);
        check_state("after_2");

        // Track wrap in both directions, reselect, out-of-range digit
        send_byte(8'h33, 1'b1); check_state("after_3");
        send_byte(8'h6E, 1'b1); check_state("after_n");
        send_byte(8'h70, 1'b1); check_state("after_p");
        send_byte(8'h33, 1'b1); check_state("reselect_3");
        send_byte(8'h37, 1'b1); check_state("after_7");

        // Volume saturation at both ends
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h2B, 1'b1); check_state("vol_up");
        end
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h2D, 1'b1); check_state("vol_down");
        end
        check_eq("vol_max", 32'(volume), 32'hFEFE);

        // Pause toggling and unpause by track select
        send_byte(8'h20, 1'b1); check_state("pause1");
        send_byte(8'h20, 1'b1); check_state("pause2");
        send_byte(8'h20, 1'b1); check_state("pause3");
        send_byte(8'h31, 1'b1); check_state("unpause_1");

        // Low stop bit, then normal recovery
        fe0 = n_fe;
        send_byte(8'h6E, 1'b0);
        check_eq("frame_err_count", 32'(n_fe - fe0), 32'd1);
        check_state("after_bad_frame");
        send_byte(8'h6E, 1'b1); check_state("after_recover");

        // Short low glitch and an unknown byte are both ignored
        fe0 = n_fe;
        @(posedge clk); #1;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * c_bit);
        check_eq("glitch_no_frame_err", 32'(n_fe - fe0), 32'd0);
        check_state("after_glitch");
        send_byte(8'h78, 1'b1); check_state("after_x");

        // Reset in the middle of a '3' frame
        @(posedge clk); #1;
        drive_bit(1'b0, c_bit);
        drive_bit(1'b1, c_bit);
        drive_bit(1'b1, c_bit);
        drive_bit(1'b0, c_bit / 2);
        init = 1'b1;
        rxd  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("mid_frame_reset");
        init = 1'b0;
        model_reset();
        repeat (3 * c_bit) @(posedge clk);
        send_byte(8'h31, 1'b1); check_state("after_reset_1");

`ifdef BT_ACK_EN
        fork
            send_byte(8'h6E, 1'b1);
            ack_capture();
        join
        check_state("after_ack");
`else
        send_byte(8'h6E, 1'b1);
        check_state("after_n_noack");
        check_eq("txd_idle", 32'(txd), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bt_cmd_decoder.md
Name: bt_cmd_decoder

Overview:
- Parametrised successor to the fixed 2-bit-track / fixed-volume Bluetooth UART command receiver.
- Receives 8N1 bytes on rxd and decodes ASCII commands into track select, VS1003-format volume (SCI_VOL), pause state and event pulses.
- Outputs feed the mp3 player, the VGA track display and the play-time counter.
- Track count, baud rate and volume step are generic.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate; BIT_CNT = CLK_HZ/BAUD (integer division).
- TRACKS, 4, number of selectable tracks (1..10).
- TRACK_W, 2, width of track output; must satisfy 2^TRACK_W >= TRACKS.
- VOL_DEFAULT, 8'h20, reset attenuation per channel.
- VOL_STEP, 8'h10, attenuation change per '+'/'-' command.
- VOL_MAX_ATT, 8'hFE, maximum attenuation (quietest).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- init  in  1  asynchronous, active-high reset.
- rxd  in  1  UART receive line, idle high, asynchronous to clk.
- track  out  TRACK_W  currently selected track, 0..TRACKS-1.
- volume  out  16  {att, att}; left and right attenuation are equal.
- paused  out  1  1 = playback paused.
- track_change  out  1  one-cycle pulse on each accepted track command.
- cmd_valid  out  1  one-cycle pulse on each recognised command.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- txd  out  1  acknowledge UART line (see Optional Feature).

Behaviour:
- Reset (async, init=1) values: track=0, volume={VOL_DEFAULT,VOL_DEFAULT}, paused=0, all pulses 0, txd=1, RX FSM=IDLE, counters 0. Reset mid-frame discards the partial byte.
- rxd passes through a 2-FF synchroniser; all RX logic uses the synchronised signal.
- RX FSM:
  - IDLE: wait for a synchronised falling edge (1 -> 0), then go to START and load the counter with BIT_CNT/2.
  - START: at count expiry, resample. If low, go to DATA with counter=BIT_CNT and bit index 0. If high, treat as a glitch and return to IDLE.
  - DATA: sample every BIT_CNT cycles, LSB first, 8 bits, then go to STOP.
  - STOP: sample after BIT_CNT cycles. If high, byte_valid pulses for one cycle. If low, frame_err pulses and the byte is discarded. Either way, return to IDLE immediately; the next start edge is accepted the following cycle.
- Decode happens on the edge after byte_valid. Outputs and cmd_valid update on that same edge, so latency is 1 clk from the stop sample.
  - '0'..'9' (0x30-0x39): if n < TRACKS, set track=n, paused=0, pulse track_change and cmd_valid. Otherwise ignore entirely.
  - 'n': track = (track==TRACKS-1) ? 0 : track+1; paused=0; pulse track_change and cmd_valid.
  - 'p': track = (track==0) ? TRACKS-1 : track-1; paused=0; pulse track_change and cmd_valid.
  - '+': att = (att < VOL_STEP) ? 0 : att-VOL_STEP; pulse cmd_valid. Saturates at 0 (loudest).
  - '-': att = (att > VOL_MAX_ATT-VOL_STEP) ? VOL_MAX_ATT : att+VOL_STEP; pulse cmd_valid. Compute in 9 bits so the sum cannot wrap.
  - ' ' (0x20): paused = ~paused; pulse cmd_valid.
  - Any other byte: no state change, no pulses.
- With TRACKS=1, 'n' and 'p' keep track=0 but still pulse track_change (restart semantics).
- Selecting the current track by digit still pulses track_change.
- track_change and cmd_valid are never asserted for more than one cycle per byte.

Optional Feature:
- Macro BT_ACK_EN.
- Defined: an 8N1 transmitter at BAUD echoes each recognised command byte on txd. Transmission starts the cycle after cmd_valid.
  - If a new command is recognised while TX is busy, its ack is dropped. The in-flight frame completes unaltered.
  - Reset forces txd=1 and aborts the frame.
- Undefined: no TX logic; txd is tied to 1.

Test Plan (CLK_HZ=100000000, BAUD=9600, BIT_CNT=10416, TRACKS=4):
- Reset, then send '2' (0x32) -> exactly 1 clk after the stop sample: track=2, track_change=1 and cmd_valid=1 for 1 cycle, paused=0, volume=16'h2020.
- From track=3 send 'n' -> track=0. Then send 'p' -> track=3. Send '7' -> no change, no pulses.
- Volume saturation:
  - From reset, send '+' three times -> volume 16'h1010, 16'h0000, 16'h0000.
  - Then send '-' 17 times -> volume 16'hF0F0 after 15 sends, 16'hFEFE after the 16th and 17th.
- Send ' ' twice -> paused 1 then 0. Send ' ' then '1' -> paused 1, then track=1 and paused=0.
- Frame with stop bit driven low -> frame_err pulses 1 cycle, no cmd_valid, outputs unchanged; the next valid byte decodes normally. A 2000-cycle low glitch on rxd -> returns to IDLE with no byte.
- Assert init mid-DATA of a '3' byte -> all outputs at reset values; a subsequent full '1' decodes to track=1. With BT_ACK_EN defined, 'n' is echoed as 0x6E on txd starting 1 clk after cmd_valid.
